iomem_dma: RTL and testbench
============================

IOMEM_DMA -- requirements
Module: iomem_dma

Interface
REQ-001 The module SHALL have parameter LEN_W, default 10, giving the width of the word-count fields.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for mem_ready per transaction.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The module SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle request to begin a transfer.
REQ-006 The module SHALL have port src_addr, input, 32 bits: first source word address.
REQ-007 The module SHALL have port dst_addr, input, 32 bits: first destination word address.
REQ-008 The module SHALL have port len, input, LEN_W bits: number of words to copy.
REQ-009 The module SHALL have port src_inc, input, 1 bit: 1 = increment source by 4 per word; 0 = fixed source (FIFO/RNG port).
REQ-010 The module SHALL have port busy, output, 1 bit: high from accepted start until the done pulse.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse at transfer end (normal or aborted).
REQ-012 The module SHALL have port err, output, 1 bit: sticky timeout flag, cleared by the next accepted start.
REQ-013 The module SHALL have port words_done, output, LEN_W bits: count of words fully written.
REQ-014 The module SHALL have port mem_valid, output, 1 bit: bus request.
REQ-015 The module SHALL have port mem_ready, input, 1 bit: responder completion.
REQ-016 The module SHALL have port mem_wstrb, output, 4 bits: 4'b0000 on reads, 4'b1111 on writes.
REQ-017 The module SHALL have ports mem_addr, output, 32 bits; mem_wdata, output, 32 bits; and mem_rdata, input, 32 bits.

Function
REQ-018 The state machine SHALL have the states IDLE, RD, RD_GAP, WR, WR_GAP and FIN.
REQ-019 In IDLE, start=1 SHALL latch src_addr, dst_addr, len and src_inc, clear err and words_done, and assert busy on the next cycle.
REQ-020 If the latched len is 0, the module SHALL go IDLE->FIN with no bus activity.
REQ-021 If the latched len is nonzero, the module SHALL enter RD.
REQ-022 mem_valid SHALL be high only in RD and WR.
REQ-023 While mem_valid is high, mem_addr, mem_wstrb and mem_wdata SHALL remain stable.
REQ-024 A transaction SHALL complete on the rising edge where mem_valid and mem_ready are both 1.
REQ-025 In RD, mem_rdata SHALL be captured into the data register on completion and the state SHALL go to RD_GAP.
REQ-026 In WR, completion SHALL increment words_done and the state SHALL go to WR_GAP.
REQ-027 RD_GAP and WR_GAP SHALL each hold mem_valid low for exactly one cycle, so a registered responder never sees a stale request.
REQ-028 RD_GAP SHALL go to WR.
REQ-029 WR_GAP SHALL go to FIN when words_done equals the latched len, otherwise to RD.
REQ-030 After each write, the destination address SHALL advance by 4; the source address SHALL advance by 4 only when src_inc=1.
REQ-031 Address arithmetic SHALL be modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
REQ-032 The timeout counter SHALL reset on entry to RD or WR and count each cycle mem_valid is high without mem_ready.
REQ-033 When the timeout counter reaches TIMEOUT, the module SHALL drop mem_valid, set err and go to FIN; words_done SHALL keep the count of completed writes.
REQ-034 FIN SHALL assert done for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-035 start while busy=1 SHALL be ignored.
REQ-036 mem_ready arriving while mem_valid=0 SHALL be ignored.

Reset
REQ-037 resetn=0 SHALL immediately force the state to IDLE.
REQ-038 resetn=0 SHALL drive busy, done, err, mem_valid to 0, mem_wstrb to 4'b0000, and mem_addr, mem_wdata, words_done to 0.
REQ-039 Reset during a transaction SHALL abandon the transaction, produce no done pulse, and let the first cycle after release be IDLE.

Configuration
REQ-040 With macro IOMEM_DMA_RETRY_ONES_EN defined, a read returning 32'hFFFF_FFFF SHALL be treated as not-ready: the module goes RD->RD_GAP->RD at the same source address, writes nothing, and does not reset the timeout counter, so persistent all-ones data ends in a timeout.
REQ-041 Without IOMEM_DMA_RETRY_ONES_EN, 32'hFFFF_FFFF SHALL be copied like any other data.

Verification
REQ-042 A bench SHALL drive len=3, src=0x0300_2000, dst=0x0300_2100, src_inc=1, with ready one cycle after valid, and check reads at 2000/2004/2008, writes at 2100/2104/2108 with matching data, words_done=3, a single done pulse, and err=0.
REQ-043 A bench SHALL drive len=0 and check done two cycles after start, mem_valid never high, and err=0.
REQ-044 A bench SHALL drive src_inc=0, src=0x0300_1000, len=2, and check both reads at 0x0300_1000 and writes to dst and dst+4.
REQ-045 A bench SHALL hold mem_ready=0 on the second write and check mem_valid drops after TIMEOUT cycles, err=1, words_done=1, one done pulse, and err cleared by the next start.
REQ-046 A bench SHALL check that with IOMEM_DMA_RETRY_ONES_EN, rdata 0xFFFF_FFFF then 0x1234_5678 yields two reads at the same address and a single write of 0x1234_5678, and that without the macro it yields a write of 0xFFFF_FFFF.
REQ-047 A bench SHALL assert resetn=0 mid-WR and check outputs are 0 asynchronously, there is no done pulse, and a fresh start after release runs normally.

Source files
------------

// File: rtl/iomem_dma_if.sv
// Memory bus between the DMA engine (master) and the memory/peripheral responder (slave).
// A request is held while mem_valid is high and completes on the clock edge where
// mem_valid and mem_ready are both 1.
interface iomem_dma_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/iomem_dma.sv
// iomem_dma: word-copy DMA engine on a valid/ready memory bus.
// Each word is a read from the source followed by a write to the destination.
// A one-cycle idle gap follows every completed access, so a registered responder
// never sees a stale request. Every access is bounded by a TIMEOUT-cycle watchdog.
// Optional feature macro IOMEM_DMA_RETRY_ONES_EN: a read returning 32'hFFFF_FFFF
// is treated as "not ready yet" and re-issued at the same source address.
module iomem_dma #(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    iomem_dma_if.master      bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic             inc_q;
    logic [31:0]      data_q;
    logic [TMO_W-1:0] tmo_q;
    logic             retry_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [LEN_W-1:0] wdone_q;
    logic             valid_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             rd_ones;

`ifdef IOMEM_DMA_RETRY_ONES_EN
    // An all-ones read means the source had nothing to give yet.
    assign rd_ones = (bus.mem_rdata == 32'hFFFF_FFFF);
`else
    assign rd_ones = 1'b0;
`endif

    // Transfer sequencer; all bus and status outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            inc_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            retry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wdone_q <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= len;
                        inc_q   <= src_inc;
                        err_q   <= 1'b0;
                        wdone_q <= '0;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        retry_q <= 1'b0;
                        if (len == '0) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= RD;
                            valid_q <= 1'b1;
                            addr_q  <= src_addr;
                            wstrb_q <= 4'b0000;
                        end
                    end
                end
                RD: begin
                    if (bus.mem_ready && !rd_ones) begin
                        data_q  <= bus.mem_rdata;
                        valid_q <= 1'b0;
                        retry_q <= 1'b0;
                        state_q <= RD_GAP;
                    end else if (tmo_q == TMO_LAST) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        // A rejected all-ones read burns a watchdog cycle too,
                        // so a stuck source still ends in a timeout.
                        tmo_q <= tmo_q + 1'b1;
                        if (bus.mem_ready) begin
                            valid_q <= 1'b0;
                            retry_q <= 1'b1;
                            state_q <= RD_GAP;
                        end
                    end
                end
                RD_GAP: begin
                    valid_q <= 1'b1;
                    if (retry_q) begin
                        state_q <= RD;
                    end else begin
                        state_q <= WR;
                        addr_q  <= dst_q;
                        wdata_q <= data_q;
                        wstrb_q <= 4'b1111;
                        tmo_q   <= '0;
                    end
                end
                WR: begin
                    if (bus.mem_ready) begin
                        valid_q <= 1'b0;
                        wstrb_q <= 4'b0000;
                        wdone_q <= wdone_q + 1'b1;
                        dst_q   <= dst_q + 32'd4;
                        if (inc_q) src_q <= src_q + 32'd4;
                        state_q <= WR_GAP;
                    end else if (tmo_q == TMO_LAST) begin
                        valid_q <= 1'b0;
                        wstrb_q <= 4'b0000;
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WR_GAP: begin
                    if (wdone_q == len_q) begin
                        state_q <= FIN;
                    end else begin
                        state_q <= RD;
                        valid_q <= 1'b1;
                        addr_q  <= src_q;
                        tmo_q   <= '0;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_done    = wdone_q;
    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_iomem_dma.sv
// Bench for iomem_dma: a negedge responder answers each request one cycle after
// mem_valid rises and checks every completed access against a queue of expected
// accesses that each scenario task fills before starting its transfer.
module tb_iomem_dma;
    localparam int LEN_W = 10;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             src_inc;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_done;

    iomem_dma_if bus();

    iomem_dma #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .src_inc    (src_inc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        sb_q[$];
    logic [31:0] rd_ovr[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          done_cnt  = 0;
    int          run       = 0;
    int          last_run  = 0;
    int          wr_seen   = 0;
    int          stall_wr  = 0;
    int          rsp_wait  = 1;
    bit          valid_seen = 1'b0;
    logic [31:0] rd_base   = 32'h0;
    int          rd_idx    = 0;

    // Responder and scoreboard: answer one cycle after valid, record each access as it is accepted.
    always @(negedge clk) begin
        txn_t        got;
        txn_t        exp;
        logic [31:0] rv;
        if (done === 1'b1) done_cnt++;
        if (bus.mem_valid === 1'b1) begin
            valid_seen = 1'b1;
            run++;
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (bus.mem_valid !== 1'b1) begin
            bus.mem_ready = 1'b0;
            rsp_wait = 1;
        end else if (bus.mem_ready !== 1'b1) begin
            if (rsp_wait > 0) begin
                rsp_wait--;
            end else if (!(bus.mem_wstrb == 4'hF && wr_seen + 1 == stall_wr)) begin
                got.strb = bus.mem_wstrb;
                got.addr = bus.mem_addr;
                got.data = (bus.mem_wstrb == 4'hF) ? bus.mem_wdata : 32'h0;
                if (bus.mem_wstrb == 4'hF) begin
                    wr_seen++;
                end else begin
                    rv = (rd_ovr.size() > 0) ? rd_ovr.pop_front() : rd_base + 32'(rd_idx);
                    rd_idx++;
                    bus.mem_rdata = rv;
                end
                bus.mem_ready = 1'b1;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got strb=%h addr=%h data=%h, required no access",
                             got.strb, got.addr, got.data);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL sb_access got strb=%h addr=%h data=%h, required strb=%h addr=%h data=%h",
                                 got.strb, got.addr, got.data, exp.strb, exp.addr, exp.data);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d,
                        input logic [LEN_W-1:0] l, input logic inc);
        src_addr = s;
        dst_addr = d;
        len      = l;
        src_inc  = inc;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        sb_q.push_back('{strb: 4'h0, addr: a, data: 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back('{strb: 4'hF, addr: a, data: d});
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        src_inc  = 1'b0;
        #12;
        n_tests++;
        if ({busy, done, err, bus.mem_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy/done/err/valid=%b, required 0000",
                     {busy, done, err, bus.mem_valid});
        end
        n_tests++;
        if ({bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, words_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus got wstrb=%h addr=%h wdata=%h words_done=%0d, required all 0",
                     bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, words_done);
        end
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_copy();
        bit ok;
        int d0;
        rd_base = 32'hA000_0000;
        rd_idx  = 0;
        push_rd(32'h0300_2000); push_wr(32'h0300_2100, 32'hA000_0000);
        push_rd(32'h0300_2004); push_wr(32'h0300_2104, 32'hA000_0001);
        push_rd(32'h0300_2008); push_wr(32'h0300_2108, 32'hA000_0002);
        d0 = done_cnt;
        kick(32'h0300_2000, 32'h0300_2100, 10'd3, 1'b1);
        repeat (3) cyc();
        // A start while busy must not disturb the running transfer.
        kick(32'hDEAD_0000, 32'hBEEF_0000, 10'd5, 1'b0);
        wait_done(200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL copy_done got no done, required done within 200 cycles"); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL copy_busy got %b, required 0 with done", busy); end
        n_tests++;
        if (words_done !== 10'd3) begin n_fail++; $display("FAIL copy_words got %0d, required 3", words_done); end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL copy_err got %b, required 0", err); end
        repeat (3) cyc();
        n_tests++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL copy_pulses got %0d, required 1", done_cnt - d0); end
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL copy_left got %0d pending, required 0", sb_q.size()); end
        sb_q.delete();
    endtask

    task automatic test_zero_len();
        int d0;
        valid_seen = 1'b0;
        d0 = done_cnt;
        kick(32'h0300_0000, 32'h0300_0100, 10'd0, 1'b1);
        n_tests++;
        if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL zero_c1 got busy/done=%b, required 10", {busy, done}); end
        cyc();
        n_tests++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL zero_c2 got busy/done=%b, required 01", {busy, done}); end
        cyc();
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_c3 got done=%b, required 0", done); end
        n_tests++;
        if (valid_seen !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_bus got valid_seen=%b err=%b, required 0 0", valid_seen, err);
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_pulses got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_fixed_src();
        bit ok;
        rd_base = 32'hB000_0000;
        rd_idx  = 0;
        push_rd(32'h0300_1000); push_wr(32'h0300_3000, 32'hB000_0000);
        push_rd(32'h0300_1000); push_wr(32'h0300_3004, 32'hB000_0001);
        kick(32'h0300_1000, 32'h0300_3000, 10'd2, 1'b0);
        wait_done(200, ok);
        n_tests++;
        if (!ok || words_done !== 10'd2) begin
            n_fail++;
            $display("FAIL fixed_done got done=%b words=%0d, required 1 2", ok, words_done);
        end
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL fixed_left got %0d pending, required 0", sb_q.size()); end
        sb_q.delete();
        cyc();
    endtask

    task automatic test_wrap();
        bit ok;
        rd_base = 32'hC000_0000;
        rd_idx  = 0;
        push_rd(32'hFFFF_FFFC); push_wr(32'hFFFF_FFF8, 32'hC000_0000);
        push_rd(32'h0000_0000); push_wr(32'hFFFF_FFFC, 32'hC000_0001);
        kick(32'hFFFF_FFFC, 32'hFFFF_FFF8, 10'd2, 1'b1);
        wait_done(200, ok);
        n_tests++;
        if (!ok || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_end got done=%b pending=%0d, required 1 0", ok, sb_q.size());
        end
        sb_q.delete();
        cyc();
    endtask

    task automatic test_timeout();
        bit ok;
        int d0;
        rd_base  = 32'hD000_0000;
        rd_idx   = 0;
        wr_seen  = 0;
        stall_wr = 2;
        push_rd(32'h0300_4000); push_wr(32'h0300_5000, 32'hD000_0000);
        push_rd(32'h0300_4004);
        d0 = done_cnt;
        kick(32'h0300_4000, 32'h0300_5000, 10'd3, 1'b1);
        wait_done(300, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL tmo_done got no done, required done within 300 cycles"); end
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b, required 1", err); end
        n_tests++;
        if (words_done !== 10'd1) begin n_fail++; $display("FAIL tmo_words got %0d, required 1", words_done); end
        n_tests++;
        if (last_run != TMO) begin n_fail++; $display("FAIL tmo_valid_len got %0d cycles, required %0d", last_run, TMO); end
        repeat (3) cyc();
        n_tests++;
        if (done_cnt - d0 != 1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_pulses got %0d pulses pending=%0d, required 1 0", done_cnt - d0, sb_q.size());
        end
        sb_q.delete();
        stall_wr = 0;
        kick(32'h0300_0000, 32'h0300_0000, 10'd0, 1'b1);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear got %b, required 0", err); end
        wait_done(20, ok);
        cyc();
    endtask

    task automatic test_retry_ones();
        bit ok;
        rd_ovr.delete();
        rd_ovr.push_back(32'hFFFF_FFFF);
        rd_ovr.push_back(32'h1234_5678);
        rd_idx = 0;
`ifdef IOMEM_DMA_RETRY_ONES_EN
        push_rd(32'h0300_6000);
        push_rd(32'h0300_6000);
        push_wr(32'h0300_7000, 32'h1234_5678);
`else
        push_rd(32'h0300_6000);
        push_wr(32'h0300_7000, 32'hFFFF_FFFF);
`endif
        kick(32'h0300_6000, 32'h0300_7000, 10'd1, 1'b1);
        wait_done(200, ok);
        n_tests++;
        if (!ok || words_done !== 10'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL ones_end got done=%b words=%0d err=%b, required 1 1 0", ok, words_done, err);
        end
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL ones_left got %0d pending, required 0", sb_q.size()); end
        sb_q.delete();
        rd_ovr.delete();
        cyc();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        int d0;
        rd_base = 32'hE000_0000;
        rd_idx  = 0;
        push_rd(32'h0300_8000); push_wr(32'h0300_9000, 32'hE000_0000);
        push_rd(32'h0300_8004);
        kick(32'h0300_8000, 32'h0300_9000, 10'd3, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.mem_valid === 1'b1 && bus.mem_wstrb === 4'hF && words_done === 10'd1) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL rst_reach got no second write, required one within 100 cycles"); end
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, err, bus.mem_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async_ctrl got busy/done/err/valid=%b, required 0000",
                     {busy, done, err, bus.mem_valid});
        end
        n_tests++;
        if ({bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, words_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_bus got wstrb=%h addr=%h wdata=%h words_done=%0d, required all 0",
                     bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, words_done);
        end
        repeat (2) cyc();
        resetn = 1'b1;
        repeat (3) cyc();
        n_tests++;
        if (done_cnt != d0 || busy !== 1'b0 || bus.mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle got pulses=%0d busy=%b valid=%b, required 0 0 0",
                     done_cnt - d0, busy, bus.mem_valid);
        end
        n_tests++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL rst_left got %0d pending, required 0", sb_q.size()); end
        sb_q.delete();
        rd_base = 32'hF000_0000;
        rd_idx  = 0;
        push_rd(32'h0300_A000); push_wr(32'h0300_B000, 32'hF000_0000);
        push_rd(32'h0300_A004); push_wr(32'h0300_B004, 32'hF000_0001);
        kick(32'h0300_A000, 32'h0300_B000, 10'd2, 1'b1);
        wait_done(200, ok);
        n_tests++;
        if (!ok || words_done !== 10'd2 || err !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_fresh got done=%b words=%0d err=%b pending=%0d, required 1 2 0 0",
                     ok, words_done, err, sb_q.size());
        end
        sb_q.delete();
        cyc();
    endtask

    initial begin
        test_reset();
        test_copy();
        test_zero_len();
        test_fixed_src();
        test_wrap();
        test_timeout();
        test_retry_ones();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
